// File: rtl/ifu_prefetch_if.sv
// ifu_prefetch_if: instruction SRAM fetch bus plus decode-side instruction handshake
interface ifu_prefetch_if;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        instr_valid_o;
   logic        instr_ready_i;
   logic [31:0] instr_o;
   logic [31:0] pc_o;
   modport master (
      output imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o,
      input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i
   );
   modport slave (
      input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o,
      output imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i
   );
endinterface

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: fetch PC, credit-limited SRAM requests, in-order instruction buffer and redirect flush
module ifu_prefetch #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          redirect_i,
   input  logic [31:0]   redirect_pc_i,
   ifu_prefetch_if.master bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [CW-1:0] out_q, out_d, disc_q, disc_d, cnt_q, cnt_d;
   logic [AW-1:0] pq_rd_q, pq_rd_d, pq_wr_q, pq_wr_d;
   logic [AW-1:0] df_rd_q, df_rd_d, df_wr_q, df_wr_d;
   logic [31:0]   pq_mem_q [FIFO_DEPTH];
   logic [31:0]   pq_mem_d [FIFO_DEPTH];
   logic [31:0]   df_instr_q [FIFO_DEPTH];
   logic [31:0]   df_instr_d [FIFO_DEPTH];
   logic [31:0]   df_pc_q [FIFO_DEPTH];
   logic [31:0]   df_pc_d [FIFO_DEPTH];
   logic [CW+1:0] used;
   logic          req, grant, drop, accept, deliver;

   // Credit check and per-cycle handshake qualifiers; a redirect voids every handshake
   always_comb begin
      used    = (CW+2)'(out_q) + (CW+2)'(disc_q) + (CW+2)'(cnt_q);
      req     = !redirect_i && (used < (CW+2)'(FIFO_DEPTH));
      grant   = req && bus.imem_gnt_i;
      drop    = bus.imem_rvalid_i && (disc_q != '0);
      accept  = bus.imem_rvalid_i && (disc_q == '0) && (out_q != '0);
      deliver = (cnt_q != '0) && !redirect_i && bus.instr_ready_i;
   end

   // Fetch PC, outstanding/discard counters and the queue of PCs awaiting their data
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      out_d      = out_q;
      disc_d     = disc_q;
      pq_rd_d    = pq_rd_q;
      pq_wr_d    = pq_wr_q;
      pq_mem_d   = pq_mem_q;
      if (redirect_i) begin
         fetch_pc_d = redirect_pc_i & 32'hFFFF_FFFC;
         disc_d     = disc_q + out_q - CW'(drop || accept);
         out_d      = '0;
         pq_rd_d    = '0;
         pq_wr_d    = '0;
      end else begin
         if (grant) begin
            pq_mem_d[pq_wr_q] = fetch_pc_q;
            pq_wr_d           = pq_wr_q + AW'(1);
            fetch_pc_d        = fetch_pc_q + 32'd4;
         end
         if (accept) pq_rd_d = pq_rd_q + AW'(1);
         out_d  = out_q + CW'(grant) - CW'(accept);
         disc_d = disc_q - CW'(drop);
      end
   end

   // Instruction buffer: accepted responses paired with their PC, popped by decode
   always_comb begin
      cnt_d      = cnt_q;
      df_rd_d    = df_rd_q;
      df_wr_d    = df_wr_q;
      df_instr_d = df_instr_q;
      df_pc_d    = df_pc_q;
      if (redirect_i) begin
         cnt_d   = '0;
         df_rd_d = '0;
         df_wr_d = '0;
      end else begin
         if (accept) begin
            df_instr_d[df_wr_q] = bus.imem_rdata_i;
            df_pc_d[df_wr_q]    = pq_mem_q[pq_rd_q];
            df_wr_d             = df_wr_q + AW'(1);
         end
         if (deliver) df_rd_d = df_rd_q + AW'(1);
         cnt_d = cnt_q + CW'(accept) - CW'(deliver);
      end
   end

   // State registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q <= RESET_PC;
         out_q      <= '0;
         disc_q     <= '0;
         cnt_q      <= '0;
         pq_rd_q    <= '0;
         pq_wr_q    <= '0;
         df_rd_q    <= '0;
         df_wr_q    <= '0;
         pq_mem_q   <= '{default: '0};
         df_instr_q <= '{default: '0};
         df_pc_q    <= '{default: '0};
      end else begin
         fetch_pc_q <= fetch_pc_d;
         out_q      <= out_d;
         disc_q     <= disc_d;
         cnt_q      <= cnt_d;
         pq_rd_q    <= pq_rd_d;
         pq_wr_q    <= pq_wr_d;
         df_rd_q    <= df_rd_d;
         df_wr_q    <= df_wr_d;
         pq_mem_q   <= pq_mem_d;
         df_instr_q <= df_instr_d;
         df_pc_q    <= df_pc_d;
      end
   end

   assign bus.imem_req_o    = req && rst_n;
   assign bus.imem_addr_o   = fetch_pc_q;
   assign bus.instr_valid_o = (cnt_q != '0) && !redirect_i;
   assign bus.instr_o       = df_instr_q[df_rd_q];
   assign bus.pc_o          = df_pc_q[df_rd_q];
endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch: table-driven vectors for the fetch stage plus wrap and async-reset sequences
module tb_ifu_prefetch;
   typedef struct {
      bit          rst;
      bit          rd;
      logic [31:0] rpc;
      bit          g;
      bit          rv;
      logic [31:0] ra;
      bit          rdy;
      bit          req;
      logic [31:0] addr;
      bit          vld;
      logic [31:0] epc;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n, rst2_n, redir, redir2;
   logic [31:0] rpc, rpc2;
   int          n_cmp = 0;
   int          n_bad = 0;
   vec_t        vq[$];

   always #5 clk = ~clk;

   ifu_prefetch_if bus ();
   ifu_prefetch_if bus2 ();

   ifu_prefetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .redirect_i(redir), .redirect_pc_i(rpc), .bus(bus.master)
   );

   ifu_prefetch #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)) dut2 (
      .clk(clk), .rst_n(rst2_n), .redirect_i(redir2), .redirect_pc_i(rpc2), .bus(bus2.master)
   );

   function automatic logic [31:0] dat(input logic [31:0] a);
      return 32'hD000_0000 | a;
   endfunction

   function automatic void add(input bit rst, input bit rd, input logic [31:0] rp, input bit g,
                               input bit rv, input logic [31:0] ra, input bit rdy, input bit req,
                               input logic [31:0] addr, input bit vld, input logic [31:0] epc);
      vec_t v;
      v.rst = rst; v.rd = rd; v.rpc = rp; v.g = g; v.rv = rv; v.ra = ra; v.rdy = rdy;
      v.req = req; v.addr = addr; v.vld = vld; v.epc = epc;
      vq.push_back(v);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic do_reset(input int i);
      @(negedge clk);
      redir = 1'b0; rpc = '0;
      bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = '0; bus.instr_ready_i = 1'b0;
      rst_n = 1'b0;
      #1;
      chk($sformatf("rst%0d.req", i), 32'(bus.imem_req_o), 32'd0);
      chk($sformatf("rst%0d.addr", i), bus.imem_addr_o, 32'h0);
      chk($sformatf("rst%0d.vld", i), 32'(bus.instr_valid_o), 32'd0);
      chk($sformatf("rst%0d.instr", i), bus.instr_o, 32'h0);
      chk($sformatf("rst%0d.pc", i), bus.pc_o, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic apply(input vec_t r, input int i);
      if (r.rst) do_reset(i);
      @(negedge clk);
      redir = r.rd; rpc = r.rpc;
      bus.imem_gnt_i = r.g; bus.imem_rvalid_i = r.rv;
      bus.imem_rdata_i = r.rv ? dat(r.ra) : 32'h0;
      bus.instr_ready_i = r.rdy;
      #1;
      chk($sformatf("v%0d.req", i), 32'(bus.imem_req_o), 32'(r.req));
      chk($sformatf("v%0d.addr", i), bus.imem_addr_o, r.addr);
      chk($sformatf("v%0d.vld", i), 32'(bus.instr_valid_o), 32'(r.vld));
      if (r.vld) begin
         chk($sformatf("v%0d.instr", i), bus.instr_o, dat(r.epc));
         chk($sformatf("v%0d.pc", i), bus.pc_o, r.epc);
      end
   endtask

   task automatic step2(input bit g, input bit rv, input logic [31:0] rd);
      @(negedge clk);
      bus2.imem_gnt_i = g; bus2.imem_rvalid_i = rv; bus2.imem_rdata_i = rd;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; rst2_n = 1'b0; redir = 1'b0; redir2 = 1'b0; rpc = '0; rpc2 = '0;
      bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = '0; bus.instr_ready_i = 1'b0;
      bus2.imem_gnt_i = 1'b0; bus2.imem_rvalid_i = 1'b0; bus2.imem_rdata_i = '0; bus2.instr_ready_i = 1'b1;
      // streaming with a 1-cycle SRAM, then gnt held low three cycles on 0x8
      add(1,0,0, 1,0,0,    1, 1,32'h0,  0,0);
      add(0,0,0, 1,1,'h0,  1, 1,32'h4,  0,0);
      add(0,0,0, 0,1,'h4,  1, 1,32'h8,  1,'h0);
      add(0,0,0, 0,0,0,    1, 1,32'h8,  1,'h4);
      add(0,0,0, 0,0,0,    1, 1,32'h8,  0,0);
      add(0,0,0, 1,0,0,    1, 1,32'h8,  0,0);
      add(0,0,0, 1,1,'h8,  1, 1,32'hC,  0,0);
      add(0,0,0, 0,1,'hC,  1, 1,32'h10, 1,'h8);
      add(0,0,0, 0,0,0,    1, 1,32'h10, 1,'hC);
      // decode stalled ten cycles: four grants, credit exhausted, then drain and restart at 0x10
      add(1,0,0, 1,0,0,    0, 1,32'h0,  0,0);
      add(0,0,0, 1,1,'h0,  0, 1,32'h4,  0,0);
      add(0,0,0, 1,1,'h4,  0, 1,32'h8,  1,'h0);
      add(0,0,0, 1,1,'h8,  0, 1,32'hC,  1,'h0);
      add(0,0,0, 0,1,'hC,  0, 0,32'h10, 1,'h0);
      for (int k = 0; k < 5; k++) add(0,0,0, 0,0,0, 0, 0,32'h10, 1,'h0);
      add(0,0,0, 0,0,0,    1, 0,32'h10, 1,'h0);
      add(0,0,0, 1,0,0,    1, 1,32'h10, 1,'h4);
      add(0,0,0, 1,1,'h10, 1, 1,32'h14, 1,'h8);
      add(0,0,0, 0,1,'h14, 1, 1,32'h18, 1,'hC);
      add(0,0,0, 0,0,0,    1, 1,32'h18, 1,'h10);
      add(0,0,0, 0,0,0,    1, 1,32'h18, 1,'h14);
      // 3-cycle SRAM, redirect to 0x1003 with two outstanding and two buffered
      add(1,0,0, 1,0,0,    0, 1,32'h0,  0,0);
      add(0,0,0, 1,0,0,    0, 1,32'h4,  0,0);
      add(0,0,0, 0,0,0,    0, 1,32'h8,  0,0);
      add(0,0,0, 0,1,'h0,  0, 1,32'h8,  0,0);
      add(0,0,0, 1,1,'h4,  0, 1,32'h8,  1,'h0);
      add(0,0,0, 1,0,0,    0, 1,32'hC,  1,'h0);
      add(0,1,32'h1003, 0,0,0, 0, 0,32'h10, 0,0);
      add(0,0,0, 1,1,'h8,  0, 1,32'h1000, 0,0);
      add(0,0,0, 0,1,'hC,  0, 1,32'h1004, 0,0);
      add(0,0,0, 0,0,0,    0, 1,32'h1004, 0,0);
      add(0,0,0, 0,1,'h1000, 0, 1,32'h1004, 0,0);
      add(0,0,0, 0,0,0,    1, 1,32'h1004, 1,'h1000);
      // redirect coinciding with rvalid and a decode handshake attempt
      add(1,0,0, 1,0,0,    0, 1,32'h0,  0,0);
      add(0,0,0, 1,1,'h0,  0, 1,32'h4,  0,0);
      add(0,0,0, 1,0,0,    0, 1,32'h8,  1,'h0);
      add(0,1,32'h2000, 0,1,'h4, 1, 0,32'hC, 0,0);
      add(0,0,0, 1,1,'h8,  1, 1,32'h2000, 0,0);
      add(0,0,0, 0,1,'h2000, 1, 1,32'h2004, 0,0);
      add(0,0,0, 0,0,0,    1, 1,32'h2004, 1,'h2000);
      add(0,0,0, 0,0,0,    1, 1,32'h2004, 0,0);
      foreach (vq[i]) apply(vq[i], i);

      // PC wrap from a high reset PC, then async reset mid-stream
      @(negedge clk);
      #1;
      chk("wrap.rst_req", 32'(bus2.imem_req_o), 32'd0);
      chk("wrap.rst_addr", bus2.imem_addr_o, 32'hFFFF_FFF8);
      @(negedge clk);
      rst2_n = 1'b1;
      step2(1'b1, 1'b0, 32'h0);
      chk("wrap.a0", bus2.imem_addr_o, 32'hFFFF_FFF8);
      chk("wrap.req0", 32'(bus2.imem_req_o), 32'd1);
      step2(1'b1, 1'b1, 32'h1111_1111);
      chk("wrap.a1", bus2.imem_addr_o, 32'hFFFF_FFFC);
      step2(1'b1, 1'b1, 32'h2222_2222);
      chk("wrap.a2", bus2.imem_addr_o, 32'h0000_0000);
      chk("wrap.vld2", 32'(bus2.instr_valid_o), 32'd1);
      chk("wrap.pc2", bus2.pc_o, 32'hFFFF_FFF8);
      chk("wrap.ins2", bus2.instr_o, 32'h1111_1111);
      step2(1'b1, 1'b1, 32'h3333_3333);
      chk("wrap.a3", bus2.imem_addr_o, 32'h0000_0004);
      chk("wrap.pc3", bus2.pc_o, 32'hFFFF_FFFC);
      chk("wrap.ins3", bus2.instr_o, 32'h2222_2222);
      #2;
      rst2_n = 1'b0;
      #1;
      chk("arst.req", 32'(bus2.imem_req_o), 32'd0);
      chk("arst.vld", 32'(bus2.instr_valid_o), 32'd0);
      chk("arst.addr", bus2.imem_addr_o, 32'hFFFF_FFF8);
      chk("arst.pc", bus2.pc_o, 32'h0);
      chk("arst.instr", bus2.instr_o, 32'h0);
      bus2.imem_gnt_i = 1'b0; bus2.imem_rvalid_i = 1'b0;
      @(negedge clk);
      rst2_n = 1'b1;
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/ifu_prefetch.md
Name: ifu_prefetch

Overview:
- Instruction fetch stage directly upstream of the decode stage.
- Holds the fetch PC and issues word reads to instruction SRAM over a request/grant/rvalid interface.
- Buffers returned instructions with their PCs in a small in-order FIFO and presents them to decode over a valid/ready handshake.
- Handles control-flow redirects from execute by flushing buffered and in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset (bits [1:0] must be 0).
- FIFO_DEPTH, 4, entries in the instruction buffer; power of 2, minimum 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- redirect_i  input  1  flush and restart fetch at redirect_pc_i.
- redirect_pc_i  input  32  new fetch PC; bits [1:0] ignored, treated as 0.
- imem_req_o  output  1  SRAM read request.
- imem_addr_o  output  32  SRAM word address (byte address, bits [1:0]=0).
- imem_gnt_i  input  1  request accepted this cycle.
- imem_rvalid_i  input  1  read data valid; in-order, one per grant, at least 1 cycle after grant.
- imem_rdata_i  input  32  read data.
- instr_valid_o  output  1  instr_o/pc_o hold a valid instruction.
- instr_ready_i  input  1  decode accepts the instruction this cycle.
- instr_o  output  32  instruction word to decode.
- pc_o  output  32  PC of instr_o.

Behaviour:
- Reset (async assert):
  - fetch_pc = RESET_PC; FIFO empty; outstanding = 0; discard = 0; pending-PC queue empty.
  - Outputs: imem_req_o = 0, imem_addr_o = RESET_PC, instr_valid_o = 0, instr_o = 0, pc_o = 0.
- State:
  - fetch_pc: 32b.
  - outstanding: granted, unreturned requests, 0..FIFO_DEPTH.
  - discard: responses still to drop, 0..FIFO_DEPTH.
  - pending-PC queue: FIFO_DEPTH entries, PCs of outstanding requests, in order.
  - Data FIFO: {instr, pc} entries, with count.
- Request:
  - imem_req_o = !redirect_i && (outstanding + discard + fifo_count < FIFO_DEPTH).
  - imem_addr_o = fetch_pc.
  - On req && gnt: push fetch_pc into the pending queue, outstanding++, fetch_pc += 4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
  - With req high and gnt low, fetch_pc and imem_addr_o hold stable. The request may be dropped only because of a redirect.
- Response:
  - If discard > 0: drop the data and decrement discard.
  - Otherwise: push {imem_rdata_i, pending-queue head} into the FIFO, pop the pending queue, outstanding--.
  - The credit rule guarantees no FIFO overflow.
  - rvalid with outstanding = discard = 0 is a protocol error; ignore it.
- Output:
  - instr_valid_o = (fifo_count != 0) && !redirect_i.
  - instr_o/pc_o = FIFO head, registered storage with no combinational path from imem_rdata_i.
  - Pop on instr_valid_o && instr_ready_i.
  - Latency: grant in cycle N, rvalid in N+1, instr_valid_o in N+2.
  - Throughput: 1 instr/cycle sustained with 1-cycle SRAM and continuous ready.
- Redirect (highest priority, one-cycle pulse or held):
  - fetch_pc <= {redirect_pc_i[31:2], 2'b00}.
  - FIFO flushed; any handshake in this cycle is void.
  - discard <= discard + outstanding − (rvalid this cycle ? 1 : 0); outstanding <= 0; pending queue cleared.
  - No request issued in the redirect cycle. The first request at the new PC comes the following cycle if credit allows.
- Simultaneous events:
  - Push and pop in the same cycle: count unchanged, order preserved.
  - Grant and rvalid in the same cycle: outstanding unchanged.
  - Redirect and grant cannot coincide, since req is low during redirect.
- Decode stall: instr_ready_i = 0 holds the FIFO head stable. Fetch stops once credit is exhausted and resumes automatically.
- Reset mid-operation: all state is cleared immediately. In-flight SRAM responses arriving after reset release are a system-level error and are not tracked.

Test Plan:
1. Reset release, 1-cycle SRAM, ready = 1 -> addresses 0x0,0x4,0x8,... on consecutive cycles; instr_valid_o first high 2 cycles after the first grant; pc_o sequence 0x0,0x4,0x8 with matching data.
2. gnt held low 3 cycles on address 0x8 -> imem_addr_o stays 0x8; no duplicate or skipped PC in the pc_o stream.
3. instr_ready_i = 0 for 10 cycles -> exactly FIFO_DEPTH (4) grants, then imem_req_o = 0; instr_o/pc_o stable; resuming ready drains 0x0..0xC in order, then fetch restarts at 0x10.
4. Redirect to 0x1003 with 2 requests outstanding and 2 entries buffered, SRAM latency 3 -> instr_valid_o = 0 in the redirect cycle; 2 late responses dropped; next issued address 0x1000; first delivered pc_o = 0x1000.
5. Redirect in the same cycle as an rvalid and an attempted decode handshake -> response dropped, handshake void, discard counts exactly the remaining outstanding requests.
6. RESET_PC = 32'hFFFF_FFF8 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; async rst_n asserted mid-stream -> instr_valid_o and imem_req_o drop to 0 without waiting for a clock edge.
